// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers: FSM state encoding plus legality and
// code-to-position decode usable by any Johnson encoder/decoder.
package johnson_pkg;

  // Widest Johnson code the helper functions accept.
  localparam int JW_MAX = 32;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  // A Johnson code has at most one boundary between its run of ones and
  // its run of zeros, so at most one adjacent bit pair may differ.
  function automatic logic johnson_legal(input logic [JW_MAX-1:0] code,
                                         input int width);
    int diffs;
    diffs = 0;
    for (int i = 0; i < JW_MAX - 1; i++) begin
      if ((i < width - 1) && (code[i] != code[i+1])) diffs++;
    end
    return (diffs <= 1);
  endfunction

  // Ones count gives the position on the filling half; once the MSB is
  // set the code is draining, so the position mirrors. All-ones lands on
  // width through the same formula (2*width - width).
  function automatic int johnson_to_pos(input logic [JW_MAX-1:0] code,
                                        input int width);
    int n;
    n = 0;
    for (int i = 0; i < JW_MAX; i++) begin
      if ((i < width) && code[i]) n++;
    end
    if (code[width-1]) return 2 * width - n;
    return n;
  endfunction

endpackage

// File: rtl/johnson_decoder_if.sv
// Sample-side and status-side signals of the Johnson decoder.
interface johnson_decoder_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  localparam int PW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0]     code_in;
  logic                 code_valid;
  logic                 err_clr;
  logic [PW-1:0]        pos;
  logic                 pos_valid;
  logic                 dir;
  logic                 step;
  logic                 illegal;
  logic                 skip;
  logic [ERR_CNT_W-1:0] err_count;

  // Source of code samples; observes the decoder status.
  modport master (
    output code_in, code_valid, err_clr,
    input  pos, pos_valid, dir, step, illegal, skip, err_count
  );

  // The decoder itself.
  modport slave (
    input  code_in, code_valid, err_clr,
    output pos, pos_valid, dir, step, illegal, skip, err_count
  );

endinterface

// File: rtl/johnson_to_bin.sv
// Combinational Johnson-code decode: legality flag and binary position.
module johnson_to_bin
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int PW   = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [PW-1:0]    k
);

  logic [JW_MAX-1:0] code_ext;

  // Widen the sample to the helper width and decode it.
  always_comb begin
    code_ext = {{(JW_MAX-WIDTH){1'b0}}, code};
    legal    = johnson_legal(code_ext, WIDTH);
    k        = PW'(johnson_to_pos(code_ext, WIDTH));
  end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code position decoder: locks onto a legal code, tracks +/-1
// steps and direction, flags illegal codes and skipped positions, and
// keeps a saturating error count.
module johnson_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  johnson_decoder_if.slave   bus
);

  localparam int PW      = $clog2(2 * WIDTH);
  localparam int NSTATES = 2 * WIDTH;

  // ---- stage p0: combinational decode of the current sample ----
  logic          legal_p0;
  logic [PW-1:0] k_p0;
  logic [PW:0]   delta_p0;

  johnson_to_bin #(.WIDTH(WIDTH)) u_to_bin (
    .code  (bus.code_in),
    .legal (legal_p0),
    .k     (k_p0)
  );

  // ---- stage p1: registered decoder state and outputs ----
  state_t               state_p1, state_nxt;
  logic [PW-1:0]        pos_p1, pos_nxt;
  logic                 dir_p1, dir_nxt;
  logic                 step_p1, step_nxt;
  logic                 illegal_p1, illegal_nxt;
  logic                 skip_p1, skip_nxt;
  logic [ERR_CNT_W-1:0] err_p1, err_nxt;
  logic                 err_event;

  // Next state, pulse outputs and error count from the current sample.
  always_comb begin
    state_nxt   = state_p1;
    pos_nxt     = pos_p1;
    dir_nxt     = dir_p1;
    step_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    skip_nxt    = 1'b0;
    err_event   = 1'b0;
    err_nxt     = err_p1;

    // Forward distance around the ring, kept non-negative.
    if (k_p0 >= pos_p1)
      delta_p0 = {1'b0, k_p0} - {1'b0, pos_p1};
    else
      delta_p0 = ({1'b0, k_p0} + (PW+1)'(NSTATES)) - {1'b0, pos_p1};

    if (bus.code_valid) begin
      if (!legal_p0) begin
        illegal_nxt = 1'b1;
        err_event   = 1'b1;
        state_nxt   = ST_UNLOCKED;
      end else begin
        unique case (state_p1)
          ST_UNLOCKED: begin
            pos_nxt   = k_p0;
            state_nxt = ST_LOCKED;
          end
          ST_LOCKED: begin
            if (delta_p0 == (PW+1)'(1)) begin
              step_nxt = 1'b1;
              dir_nxt  = 1'b1;
              pos_nxt  = k_p0;
            end else if (delta_p0 == (PW+1)'(NSTATES - 1)) begin
              step_nxt = 1'b1;
              dir_nxt  = 1'b0;
              pos_nxt  = k_p0;
            end else if (delta_p0 != '0) begin
              skip_nxt  = 1'b1;
              err_event = 1'b1;
              pos_nxt   = k_p0;
            end
          end
          default: state_nxt = ST_UNLOCKED;
        endcase
      end
    end

    // A clear wipes earlier history; an error in the same cycle still counts.
    if (bus.err_clr)
      err_nxt = err_event ? ERR_CNT_W'(1) : '0;
    else if (err_event && (err_p1 != {ERR_CNT_W{1'b1}}))
      err_nxt = err_p1 + ERR_CNT_W'(1);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_p1   <= ST_UNLOCKED;
      pos_p1     <= '0;
      dir_p1     <= 1'b1;
      step_p1    <= 1'b0;
      illegal_p1 <= 1'b0;
      skip_p1    <= 1'b0;
      err_p1     <= '0;
    end else begin
      state_p1   <= state_nxt;
      pos_p1     <= pos_nxt;
      dir_p1     <= dir_nxt;
      step_p1    <= step_nxt;
      illegal_p1 <= illegal_nxt;
      skip_p1    <= skip_nxt;
      err_p1     <= err_nxt;
    end
  end

  assign bus.pos       = pos_p1;
  assign bus.pos_valid = (state_p1 == ST_LOCKED);
  assign bus.dir       = dir_p1;
  assign bus.step      = step_p1;
  assign bus.illegal   = illegal_p1;
  assign bus.skip      = skip_p1;
  assign bus.err_count = err_p1;

endmodule

// File: tb/tb_johnson_decoder.sv
// Scoreboard bench for johnson_decoder (WIDTH=4, ERR_CNT_W=8): directed
// scenarios followed by randomized traffic against a table-based model.
module tb_johnson_decoder;

  localparam int W    = 4;
  localparam int EW   = 8;
  localparam int NS   = 2 * W;
  localparam int PW   = $clog2(NS);
  localparam int EMAX = (1 << EW) - 1;

  logic clock;
  logic reset_n;

  johnson_decoder_if #(.WIDTH(W), .ERR_CNT_W(EW)) bus ();

  johnson_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int pos;
    int pos_valid;
    int dir;
    int step;
    int illegal;
    int skip;
    int err;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state
  int m_locked = 0;
  int m_pos    = 0;
  int m_dir    = 1;
  int m_err    = 0;

  // The 2*W legal codes listed by position: fill ones from the LSB, then
  // clear them from the LSB.
  function automatic logic [W-1:0] code_of(input int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = ((1 << W) - 1) & ~((1 << (k - W)) - 1);
    return W'(v);
  endfunction

  function automatic int lookup(input logic [W-1:0] c);
    for (int k = 0; k < NS; k++) if (code_of(k) == c) return k;
    return -1;
  endfunction

  // Apply one cycle of inputs and queue the response expected after the edge.
  task automatic drive(input logic rst_n, input logic valid,
                       input logic [W-1:0] code, input logic clr);
    exp_t e;
    int   idx, d, ev;
    @(negedge clock);
    reset_n        = rst_n;
    bus.code_valid = valid;
    bus.code_in    = code;
    bus.err_clr    = clr;
    e.step = 0; e.illegal = 0; e.skip = 0;
    if (!rst_n) begin
      m_locked = 0; m_pos = 0; m_dir = 1; m_err = 0;
    end else begin
      ev = 0;
      if (valid) begin
        idx = lookup(code);
        if (idx < 0) begin
          e.illegal = 1; ev = 1; m_locked = 0;
        end else if (!m_locked) begin
          m_locked = 1; m_pos = idx;
        end else begin
          d = (idx - m_pos + NS) % NS;
          if (d == 1)           begin e.step = 1; m_dir = 1; m_pos = idx; end
          else if (d == NS - 1) begin e.step = 1; m_dir = 0; m_pos = idx; end
          else if (d != 0)      begin e.skip = 1; ev = 1; m_pos = idx; end
        end
      end
      if (clr) m_err = ev;
      else if (ev && m_err < EMAX) m_err++;
    end
    e.pos = m_pos; e.pos_valid = m_locked; e.dir = m_dir; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: each edge yields one registered response to score.
  always begin
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (int'(bus.pos) != e.pos || int'(bus.pos_valid) != e.pos_valid ||
          int'(bus.dir) != e.dir || int'(bus.step) != e.step ||
          int'(bus.illegal) != e.illegal || int'(bus.skip) != e.skip ||
          int'(bus.err_count) != e.err) begin
        n_fail++;
        $display("FAIL cycle%0d: got pos=%0d pv=%0d dir=%0d step=%0d ill=%0d skip=%0d err=%0d, expected pos=%0d pv=%0d dir=%0d step=%0d ill=%0d skip=%0d err=%0d",
                 cyc, bus.pos, bus.pos_valid, bus.dir, bus.step, bus.illegal,
                 bus.skip, bus.err_count, e.pos, e.pos_valid, e.dir, e.step,
                 e.illegal, e.skip, e.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r, wait_cnt;
    logic [W-1:0] c;
    reset_n = 1'b0; bus.code_valid = 1'b0; bus.code_in = '0; bus.err_clr = 1'b0;

    // Reset, then the full up sequence back to 0000
    drive(0, 0, '0, 0);
    drive(0, 1, 4'b0011, 1);
    for (int i = 0; i <= NS; i++) drive(1, 1, code_of(i % NS), 0);

    // Wrap-around downwards from position 0
    drive(1, 1, 4'b1000, 0);
    drive(1, 1, 4'b1100, 0);
    drive(1, 1, 4'b1110, 0);

    // Skip: relock to pos 1 via reset, then jump two positions
    drive(0, 0, '0, 0);
    drive(1, 1, 4'b0001, 0);
    drive(1, 1, 4'b0111, 0);

    // Illegal while locked, then relock without a step
    drive(1, 1, 4'b0101, 0);
    drive(1, 1, 4'b0011, 0);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) drive(1, 1, 4'b1001, 0);
    @(posedge clock); #2;
    chk("err_saturated", int'(bus.err_count), EMAX);
    drive(1, 1, 4'b1001, 1);
    @(posedge clock); #2;
    chk("err_clr_with_error", int'(bus.err_count), 1);

    // Mid-stream reset with a valid code present
    drive(1, 1, 4'b0011, 0);
    drive(0, 1, 4'b0111, 1);
    @(posedge clock); #2;
    chk("reset_pos_valid", int'(bus.pos_valid), 0);
    chk("reset_dir", int'(bus.dir), 1);
    drive(1, 1, 4'b1110, 0);
    @(posedge clock); #2;
    chk("relock_pos", int'(bus.pos), 5);
    chk("relock_no_step", int'(bus.step), 0);
    // Repeats and gaps
    drive(1, 1, 4'b1110, 0);
    drive(1, 0, 4'b0101, 0);
    drive(1, 0, 4'b0001, 1);
    drive(1, 1, 4'b1110, 0);
    drive(1, 1, 4'b1100, 0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        k = (m_pos + NS + $urandom_range(0, 2) - 1) % NS;
        c = code_of(k);
      end else if (r < 85) begin
        c = code_of($urandom_range(0, NS - 1));
      end else begin
        c = W'($urandom_range(0, (1 << W) - 1));
      end
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 85), c,
            ($urandom_range(0, 49) == 0));
    end
    drive(1, 0, '0, 0);

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 10) begin
      @(posedge clock);
      wait_cnt++;
    end
    @(negedge clock);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
